cache_miss_ctrl: RTL and testbench

- Miss/refill and write-through sequencer between the data cache and data memory.
- Read hits: pass with no stall.
- Read misses: stall the pipeline, fetch the word from memory over a req/ack handshake, then drive FoundData plus a one-cycle fill strobe into the cache's MemRead input.
- All stores: written through to memory; the cache updates itself on a hit and bypasses on a miss.

---
 rtl/cache_miss_ctrl.sv | 124 ++++++++++++
 tb/tb_cache_miss_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
// Miss/refill and write-through sequencer between the data cache and data memory.
// Define CACHE_PERF_CNT_EN to add saturating hit/miss/write counter outputs.
module cache_miss_ctrl #(
    parameter int ADDRESS_WIDTH = 17,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     MemRead,
    input  logic [3:0]               WE,
    input  logic [ADDRESS_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0]    WD,
    input  logic                     hit_i,
    output logic                     Stall,
    output logic                     FillEn,
    output logic [DATA_WIDTH-1:0]    FoundData,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [3:0]               mem_be,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]              hit_cnt,
    output logic [31:0]              miss_cnt,
    output logic [31:0]              wr_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, DONE} state_t;

    state_t state;
    logic   busy;
    logic   store_req;
    logic   miss_req;
    logic   unused_a;

    assign store_req = |WE;
    assign miss_req  = MemRead & ~hit_i;
    assign unused_a  = ^A[1:0];

    // The first stall cycle must appear in the same cycle as the request, so the
    // IDLE term is combinational; the memory-wait term comes from a register.
    assign Stall = busy | ((state == IDLE) & ~RST & (store_req | miss_req));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            FillEn    <= 1'b0;
            FoundData <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    FillEn <= 1'b0;
                    if (store_req) begin
                        mem_addr  <= {A[ADDRESS_WIDTH-1:2], 2'b00};
                        mem_wdata <= WD;
                        mem_be    <= WE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= WR_REQ;
                    end else if (miss_req) begin
                        mem_addr  <= {A[ADDRESS_WIDTH-1:2], 2'b00};
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (mem_ack) begin
                        FoundData <= mem_rdata;
                        FillEn    <= 1'b1;
                        mem_req   <= 1'b0;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                WR_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // Requests seen here are ignored; IDLE re-evaluates them next cycle.
                    FillEn <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wr_cnt   <= '0;
        end else if (state == IDLE) begin
            if (MemRead & hit_i & ~store_req & (hit_cnt != 32'hFFFF_FFFF))
                hit_cnt <= hit_cnt + 32'd1;
            if (store_req) begin
                if (wr_cnt != 32'hFFFF_FFFF) wr_cnt <= wr_cnt + 32'd1;
            end else if (miss_req) begin
                if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: scoreboarded memory requests and refill data.
module tb_cache_miss_ctrl;
    localparam int AW = 17;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          MemRead;
    logic [3:0]    WE;
    logic [AW-1:0] A;
    logic [DW-1:0] WD;
    logic          hit_i;
    logic          Stall, FillEn, mem_req, mem_we, mem_ack;
    logic [DW-1:0] FoundData, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0]   hit_cnt, miss_cnt, wr_cnt;
    int            exp_hit = 0, exp_miss = 0, exp_wr = 0;
`endif

    always #5 CLK = ~CLK;

    cache_miss_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .MemRead(MemRead), .WE(WE), .A(A), .WD(WD), .hit_i(hit_i),
        .Stall(Stall), .FillEn(FillEn), .FoundData(FoundData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wr_cnt(wr_cnt)
`endif
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    be;
    } mreq_t;

    mreq_t         req_q[$];
    logic [DW-1:0] rd_q[$];
    int            n_chk  = 0;
    int            n_pass = 0;
    int            n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        MemRead = 1'b0;
        WE      = 4'b0000;
        hit_i   = 1'b0;
    endtask

    // One pipeline access; lat is the memory response time in cycles (>= 1).
    task automatic access(input logic rd, input logic [3:0] we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic hit, input int lat,
                          input logic [DW-1:0] rdata, input string tag);
        mreq_t         push, got;
        logic          is_wr, miss;
        int            stalls;
        is_wr = |we;
        miss  = rd & ~hit & ~is_wr;
        if (is_wr || miss) begin
            push.we    = is_wr;
            push.addr  = {a[AW-1:2], 2'b00};
            push.wdata = wd;
            push.be    = we;
            req_q.push_back(push);
            if (miss) rd_q.push_back(rdata);
        end
`ifdef CACHE_PERF_CNT_EN
        if (is_wr) exp_wr++;
        else if (miss) exp_miss++;
        else if (rd && hit) exp_hit++;
`endif
        MemRead = rd; WE = we; A = a; WD = wd; hit_i = hit;
        @(negedge CLK);
        stalls = int'(Stall);
        chk({tag, " idle stall"}, Stall, is_wr | miss);
        chk({tag, " idle mem_req"}, mem_req, 1'b0);
        chk({tag, " idle fillen"}, FillEn, 1'b0);
        step();
        if (!(is_wr || miss)) begin
            idle_in();
            return;
        end
        for (int c = 1; c <= lat; c++) begin
            if (c == lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            @(negedge CLK);
            stalls += int'(Stall);
            chk({tag, " mem_req held"}, mem_req, 1'b1);
            if (c == 1) begin
                got = req_q.pop_front();
                chk({tag, " mem_we"}, mem_we, got.we);
                chk({tag, " mem_addr"}, mem_addr, got.addr);
                if (got.we) begin
                    chk({tag, " mem_wdata"}, mem_wdata, got.wdata);
                    chk({tag, " mem_be"}, mem_be, got.be);
                end
            end
            step();
            mem_ack   = 1'b0;
            mem_rdata = 32'h0BAD_0BAD;
        end
        @(negedge CLK);
        chk({tag, " done stall"}, Stall, 1'b0);
        chk({tag, " done fillen"}, FillEn, miss);
        chk({tag, " done mem_req"}, mem_req, 1'b0);
        chk({tag, " stall cycles"}, 64'(stalls), 64'(lat + 1));
        if (miss) chk({tag, " founddata"}, FoundData, rd_q.pop_front());
        step();
        idle_in();
        @(negedge CLK);
        chk({tag, " post fillen"}, FillEn, 1'b0);
        chk({tag, " post stall"}, Stall, 1'b0);
        step();
    endtask

    initial begin
        RST = 1'b1; MemRead = 1'b0; WE = '0; A = '0; WD = '0; hit_i = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        step();
        step();
        @(negedge CLK);
        chk("rst stall", Stall, 1'b0);
        chk("rst fillen", FillEn, 1'b0);
        chk("rst mem_req", mem_req, 1'b0);
        chk("rst mem_we", mem_we, 1'b0);
        chk("rst founddata", FoundData, '0);
        chk("rst mem_addr", mem_addr, '0);
        chk("rst mem_wdata", mem_wdata, '0);
        chk("rst mem_be", mem_be, '0);
        RST = 1'b0;
        step();

        access(1'b1, 4'b0000, 17'h00104, '0, 1'b1, 1, '0, "hit0");
        access(1'b1, 4'b0000, 17'h00104, '0, 1'b1, 1, '0, "hit1");
        access(1'b1, 4'b0000, 17'h00107, '0, 1'b0, 3, 32'hDEADBEEF, "miss3");
        access(1'b0, 4'b0011, 17'h00208, 32'h12345678, 1'b0, 1, '0, "st_miss");
        access(1'b0, 4'b0011, 17'h00208, 32'h12345678, 1'b1, 1, '0, "st_hit");
        @(negedge CLK);
        chk("founddata hold", FoundData, 32'hDEADBEEF);
        step();
        access(1'b1, 4'b1111, 17'h0030C, 32'hA5A5_5A5A, 1'b0, 2, '0, "rd_wr_prio");
        access(1'b1, 4'b0000, 17'h1FFFF, '0, 1'b0, 1, 32'hCAFEF00D, "miss_top");

        // Stray ack with nothing outstanding
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        @(negedge CLK);
        chk("stray ack mem_req", mem_req, 1'b0);
        chk("stray ack fillen", FillEn, 1'b0);
        chk("stray ack stall", Stall, 1'b0);
        chk("stray ack founddata", FoundData, 32'hCAFEF00D);
        step();

`ifdef CACHE_PERF_CNT_EN
        @(negedge CLK);
        chk("hit_cnt", hit_cnt, 64'(exp_hit));
        chk("miss_cnt", miss_cnt, 64'(exp_miss));
        chk("wr_cnt", wr_cnt, 64'(exp_wr));
        step();
`endif

        // Reset while a refill is outstanding
        MemRead = 1'b1; hit_i = 1'b0; A = 17'h00400;
        @(negedge CLK);
        chk("rstmiss idle stall", Stall, 1'b1);
        step();
        @(negedge CLK);
        chk("rstmiss mem_req", mem_req, 1'b1);
        step();
        RST = 1'b1;
        MemRead = 1'b0;
        step();
        @(negedge CLK);
        chk("rstmiss mem_req drop", mem_req, 1'b0);
        chk("rstmiss stall", Stall, 1'b0);
        chk("rstmiss fillen", FillEn, 1'b0);
        step();
        RST = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h7777_7777;
        step();
        mem_ack = 1'b0;
        @(negedge CLK);
        chk("late ack fillen", FillEn, 1'b0);
        chk("late ack mem_req", mem_req, 1'b0);
        chk("late ack stall", Stall, 1'b0);
        chk("late ack founddata", FoundData, '0);
`ifdef CACHE_PERF_CNT_EN
        chk("rst hit_cnt", hit_cnt, '0);
        chk("rst miss_cnt", miss_cnt, '0);
        chk("rst wr_cnt", wr_cnt, '0);
`endif
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
